// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory.
// Each accepted request gets one ACCESS cycle on the memory bus and then
// a one-cycle ackN pulse. The memory itself is external and reads
// combinationally.
// Optional build macro DATA_MEM_ARB_ADDR_CHECK_EN: reject misaligned or
// out-of-range addresses with errN instead of touching memory.
//
// state  | meaning
// IDLE   | memory bus parked at zero, arbitrating eligible requests
// ACCESS | latched request drives the memory bus for one cycle
module data_mem_arbiter #(
  parameter int NUM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        err0,
  output logic        err1,
  output logic        mem_write_enable,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output logic        busy
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACCESS = 1'b1;

  if (NUM_WORDS < 1) begin : g_depth_check
    $error("data_mem_arbiter: NUM_WORDS must be at least 1");
  end

  logic [0:0]  state;
  logic        lat_id;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic        last_grant;
  logic        elig0;
  logic        elig1;
  logic        grant1;
  logic        in_access;
  logic        addr_bad;

  // A port whose ack is pulsing this cycle is still holding req for the
  // request just completed, so it must not be accepted again.
  assign elig0  = req0 & ~ack0;
  assign elig1  = req1 & ~ack1;
  // On a tie the port that did not win last time goes next.
  assign grant1 = elig1 & (~elig0 | ~last_grant);

  assign in_access = (state == S_ACCESS);

`ifdef DATA_MEM_ARB_ADDR_CHECK_EN
  // Rejected requests still take their ACCESS slot but never touch memory.
  assign addr_bad = (lat_addr[1:0] != 2'b00) || (lat_addr[31:2] >= 30'(NUM_WORDS));
`else
  assign addr_bad = 1'b0;
`endif

  // Memory bus is combinational from state so an async reset pulls
  // mem_write_enable low at once, dropping any pending write.
  always_comb begin
    mem_write_enable = in_access & lat_we & ~addr_bad;
    mem_address      = in_access ? lat_addr  : 32'h0;
    mem_write_data   = in_access ? lat_wdata : 32'h0;
    busy             = in_access;
  end

  // Arbitration FSM, request latch, acks and read data capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      lat_id     <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= 32'h0;
      lat_wdata  <= 32'h0;
      last_grant <= 1'b1;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata0     <= 32'h0;
      rdata1     <= 32'h0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        S_IDLE: begin
          if (elig0 | elig1) begin
            lat_id    <= grant1;
            lat_we    <= grant1 ? we1    : we0;
            lat_addr  <= grant1 ? addr1  : addr0;
            lat_wdata <= grant1 ? wdata1 : wdata0;
            state     <= S_ACCESS;
          end
        end
        default: begin
          if (lat_id) begin
            ack1 <= 1'b1;
            if (!lat_we && !addr_bad) rdata1 <= mem_read_data;
          end else begin
            ack0 <= 1'b1;
            if (!lat_we && !addr_bad) rdata0 <= mem_read_data;
          end
          last_grant <= lat_id;
          state      <= S_IDLE;
        end
      endcase
    end
  end

`ifdef DATA_MEM_ARB_ADDR_CHECK_EN
  // Error pulses ride alongside the ack of a rejected request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err0 <= 1'b0;
      err1 <= 1'b0;
    end else begin
      err0 <= in_access & ~lat_id & addr_bad;
      err1 <= in_access &  lat_id & addr_bad;
    end
  end
`else
  assign err0 = 1'b0;
  assign err1 = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter with a behavioural 64-word memory.
module tb_data_mem_arbiter;

  typedef struct {
    bit          is_rd;
    bit          err;
    logic [31:0] rd;
  } sb_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic        mem_write_enable;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic        busy;

  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];
  sb_t         q0[$];
  sb_t         q1[$];
  int          ack_port[$];
  int          ack_cyc[$];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  data_mem_arbiter #(.NUM_WORDS(64)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .err0(err0), .err1(err1),
    .mem_write_enable(mem_write_enable), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign mem_read_data = mem[mem_address[7:2]];
  always @(posedge clk) if (mem_write_enable) mem[mem_address[7:2]] <= mem_write_data;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic bit addr_rejected(input logic [31:0] a);
`ifdef DATA_MEM_ARB_ADDR_CHECK_EN
    return (a[1:0] != 2'b00) || (a[31:2] >= 30'd64);
`else
    return 1'b0;
`endif
  endfunction

  // Scoreboard: every ack pops its port's queue and is compared there.
  always @(negedge clk) begin
    sb_t e;
    check_val("ack_overlap", {31'h0, ack0 & ack1}, 32'h0);
    if (ack0) begin
      ack_port.push_back(0);
      ack_cyc.push_back(cyc);
      if (q0.size() == 0) check_val("ack0_unexpected", 32'h1, 32'h0);
      else begin
        e = q0.pop_front();
        check_val("err0", {31'h0, err0}, {31'h0, e.err});
        if (e.is_rd) check_val("rdata0", rdata0, e.rd);
      end
    end
    if (ack1) begin
      ack_port.push_back(1);
      ack_cyc.push_back(cyc);
      if (q1.size() == 0) check_val("ack1_unexpected", 32'h1, 32'h0);
      else begin
        e = q1.pop_front();
        check_val("err1", {31'h0, err1}, {31'h0, e.err});
        if (e.is_rd) check_val("rdata1", rdata1, e.rd);
      end
    end
  end

  task automatic expect_txn(input bit p, input bit w, input logic [31:0] a, input logic [31:0] d);
    sb_t e;
    e.err   = addr_rejected(a);
    e.is_rd = !w && !e.err;
    e.rd    = ref_mem[a[7:2]];
    if (w && !e.err) ref_mem[a[7:2]] = d;
    if (p) q1.push_back(e); else q0.push_back(e);
  endtask

  // One isolated request: drive after edge k, expect ACCESS after k+1
  // and the ack pulse after k+2.
  task automatic do_req(input bit p, input bit w, input logic [31:0] a, input logic [31:0] d);
    bit rej;
    rej = addr_rejected(a);
    expect_txn(p, w, a, d);
    @(posedge clk); #1;
    if (p) begin req1 = 1; we1 = w; addr1 = a; wdata1 = d; end
    else   begin req0 = 1; we0 = w; addr0 = a; wdata0 = d; end
    @(posedge clk); #1;
    check_val("access_busy", {31'h0, busy}, 32'h1);
    check_val("access_addr", mem_address, a);
    check_val("access_we", {31'h0, mem_write_enable}, {31'h0, w & ~rej});
    if (w) check_val("access_wdata", mem_write_data, d);
    @(posedge clk); #1;
    check_val("ack_latency", {31'h0, p ? ack1 : ack0}, 32'h1);
    if (p) req1 = 0; else req0 = 0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]     = 32'h0;
      ref_mem[i] = 32'h0;
    end
    reset = 1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_ack", {30'h0, ack1, ack0}, 32'h0);
    check_val("rst_err", {30'h0, err1, err0}, 32'h0);
    check_val("rst_rdata0", rdata0, 32'h0);
    check_val("rst_rdata1", rdata1, 32'h0);
    check_val("rst_busy", {31'h0, busy}, 32'h0);
    check_val("rst_mem_bus", mem_address | mem_write_data | {31'h0, mem_write_enable}, 32'h0);
    @(negedge clk) reset = 0;

    // Single write then read-back from the other port, with hold check.
    do_req(0, 1, 32'h10, 32'hDEADBEEF);
    do_req(1, 0, 32'h10, 32'h0);
    @(posedge clk); #1;
    check_val("ack1_drop", {31'h0, ack1}, 32'h0);
    check_val("rdata1_hold", rdata1, 32'hDEADBEEF);
    check_val("idle_mem_bus", mem_address | mem_write_data | {31'h0, mem_write_enable}, 32'h0);

    // Mixed traffic including the last word.
    for (int i = 0; i < 6; i++) begin
      logic [31:0] a;
      a = {24'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'b00};
      do_req(i[0], 1, a, $urandom);
      do_req(~i[0], 0, a, 32'h0);
    end
    do_req(1, 1, 32'hFC, 32'hA5A5_0FF0);
    do_req(0, 0, 32'hFC, 32'h0);

    // Misaligned / beyond-depth addresses; word 0 read back either way.
    do_req(0, 1, 32'h102, 32'h1234_5678);
    do_req(0, 1, 32'h100, 32'h8765_4321);
    do_req(1, 0, 32'h0, 32'h0);

    // Reset while a write of 0x55 to 0x20 sits in ACCESS.
    @(posedge clk); #1;
    req0 = 1; we0 = 1; addr0 = 32'h20; wdata0 = 32'h55;
    @(posedge clk); #1;
    check_val("rmw_we_before", {31'h0, mem_write_enable}, 32'h1);
    reset = 1;
    #1;
    check_val("rmw_we_async", {31'h0, mem_write_enable}, 32'h0);
    check_val("rmw_busy_async", {31'h0, busy}, 32'h0);
    req0 = 0;
    @(posedge clk); #1;
    check_val("rmw_no_ack", {30'h0, ack1, ack0}, 32'h0);
    check_val("rmw_word8", mem[8], ref_mem[8]);

    // Contention from reset: both ports read continuously.
    req0 = 1; we0 = 0; addr0 = 32'h10;
    req1 = 1; we1 = 0; addr1 = 32'h20;
    for (int i = 0; i < 2; i++) begin
      expect_txn(0, 0, 32'h10, 32'h0);
      expect_txn(1, 0, 32'h20, 32'h0);
    end
    ack_port.delete();
    ack_cyc.delete();
    @(negedge clk) reset = 0;
    for (int i = 0; i < 20 && ack_port.size() < 4; i++) begin
      @(negedge clk); #1;
    end
    req0 = 0; req1 = 0;
    if (ack_port.size() < 4) check_val("cont_timeout", ack_port.size(), 32'd4);
    else begin
      for (int i = 0; i < 4; i++) check_val("cont_order", ack_port[i], i % 2);
      for (int i = 1; i < 4; i++) check_val("cont_spacing", ack_cyc[i] - ack_cyc[i-1], 32'd2);
    end

    repeat (4) @(posedge clk);
    #1;
    check_val("sb_drain", q0.size() + q1.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
